// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage.
// Word-organised data RAM with byte/half/word stores, zero-latency
// sign/zero-extended loads, and two memory-mapped registers
// (free-running cycle counter and a GPIO output latch) at 0xFFFFFFF0.
module mem_stage #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] alu_resultM,
  input  logic [31:0] write_dataM,
  output logic [31:0] dmem_resultM,
  output logic        misalignM,
  output logic [31:0] gpio_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Storage
  logic [31:0]   ram_r [DEPTH_WORDS];
  logic [31:0]   cycle_cnt_r;
  logic [31:0]   gpio_r;

  // Decode / datapath
  logic          is_mmio_s;
  logic [AW-1:0] word_idx_s;
  logic [1:0]    lane_s;
  logic [1:0]    size_s;
  logic          misalign_s;
  logic          size_ok_s;
  logic          store_ok_s;
  logic          ram_we_s;
  logic          gpio_we_s;
  logic [3:0]    byte_en_s;
  logic [31:0]   store_lanes_s;
  logic [31:0]   mmio_word_s;
  logic [31:0]   load_word_s;
  logic [7:0]    load_byte_s;
  logic [15:0]   load_half_s;
  logic [31:0]   load_result_s;

  assign is_mmio_s  = (alu_resultM[31:4] == 28'hFFFFFFF);
  assign word_idx_s = alu_resultM[AW+1:2];
  assign lane_s     = alu_resultM[1:0];
  assign size_s     = funct3M[1:0];

  // Misalignment: halfword on odd byte, word on any non-zero lane offset.
  always_comb begin
    misalign_s = 1'b0;
    if (mem_readM || mem_writeM) begin
      misalign_s = ((size_s == 2'b01) && lane_s[0]) ||
                   ((size_s == 2'b10) && (lane_s != 2'b00));
    end else begin
      misalign_s = 1'b0;
    end
  end

  // Store lane enables and lane-replicated store data; only SB/SH/SW write.
  always_comb begin
    byte_en_s     = 4'b0000;
    store_lanes_s = 32'h0000_0000;
    size_ok_s     = 1'b0;
    case (funct3M)
      3'b000: begin
        size_ok_s     = 1'b1;
        store_lanes_s = {4{write_dataM[7:0]}};
        case (lane_s)
          2'b00:   byte_en_s = 4'b0001;
          2'b01:   byte_en_s = 4'b0010;
          2'b10:   byte_en_s = 4'b0100;
          2'b11:   byte_en_s = 4'b1000;
          default: byte_en_s = 4'b0000;
        endcase
      end
      3'b001: begin
        size_ok_s     = 1'b1;
        store_lanes_s = {2{write_dataM[15:0]}};
        byte_en_s     = lane_s[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        size_ok_s     = 1'b1;
        store_lanes_s = write_dataM;
        byte_en_s     = 4'b1111;
      end
      default: begin
        size_ok_s     = 1'b0;
        store_lanes_s = 32'h0000_0000;
        byte_en_s     = 4'b0000;
      end
    endcase
  end

  // A store commits only when legal, aligned and out of reset.
  assign store_ok_s = mem_writeM & size_ok_s & ~misalign_s & rst_n;
  assign ram_we_s   = store_ok_s & ~is_mmio_s;
  assign gpio_we_s  = store_ok_s & is_mmio_s & (alu_resultM[3:2] == 2'b01);

  // RAM byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          ram_r[word_idx_s][8*i +: 8] <= store_lanes_s[8*i +: 8];
        end
      end
    end
  end

  // Free-running cycle counter, cleared while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_r <= 32'h0000_0000;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
    end
  end

  // GPIO latch with byte-lane writes, cleared while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_r <= 32'h0000_0000;
    end else if (gpio_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          gpio_r[8*i +: 8] <= store_lanes_s[8*i +: 8];
        end
      end
    end
  end

  assign gpio_out = gpio_r;

  // MMIO read mux: counter, GPIO, then two reserved zero words.
  always_comb begin
    mmio_word_s = 32'h0000_0000;
    case (alu_resultM[3:2])
      2'b00:   mmio_word_s = cycle_cnt_r;
      2'b01:   mmio_word_s = gpio_r;
      default: mmio_word_s = 32'h0000_0000;
    endcase
  end

  // Addressed word (pre-store contents give read-before-write for free).
  always_comb begin
    load_word_s = 32'h0000_0000;
    if (is_mmio_s) begin
      load_word_s = mmio_word_s;
    end else begin
      load_word_s = ram_r[word_idx_s];
    end
  end

  // Byte and halfword selection by lane offset.
  always_comb begin
    load_byte_s = 8'h00;
    case (lane_s)
      2'b00:   load_byte_s = load_word_s[7:0];
      2'b01:   load_byte_s = load_word_s[15:8];
      2'b10:   load_byte_s = load_word_s[23:16];
      2'b11:   load_byte_s = load_word_s[31:24];
      default: load_byte_s = 8'h00;
    endcase
    load_half_s = lane_s[1] ? load_word_s[31:16] : load_word_s[15:0];
  end

  // Load extension; zero when idle, misaligned or funct3 is not a load size.
  always_comb begin
    load_result_s = 32'h0000_0000;
    if (!mem_readM || misalign_s) begin
      load_result_s = 32'h0000_0000;
    end else begin
      case (funct3M)
        3'b000:  load_result_s = {{24{load_byte_s[7]}}, load_byte_s};
        3'b001:  load_result_s = {{16{load_half_s[15]}}, load_half_s};
        3'b010:  load_result_s = load_word_s;
        3'b100:  load_result_s = {24'h00_0000, load_byte_s};
        3'b101:  load_result_s = {16'h0000, load_half_s};
        default: load_result_s = 32'h0000_0000;
      endcase
    end
  end

  assign dmem_resultM = load_result_s;
  assign misalignM    = misalign_s;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test-plan steps followed by randomized accesses,
// each cycle checked against a byte-addressed reference model.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk;
  logic        rst_n;
  logic        mem_readM;
  logic        mem_writeM;
  logic [2:0]  funct3M;
  logic [31:0] alu_resultM;
  logic [31:0] write_dataM;
  logic [31:0] dmem_resultM;
  logic        misalignM;
  logic [31:0] gpio_out;

  mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_readM    (mem_readM),
    .mem_writeM   (mem_writeM),
    .funct3M      (funct3M),
    .alu_resultM  (alu_resultM),
    .write_dataM  (write_dataM),
    .dmem_resultM (dmem_resultM),
    .misalignM    (misalignM),
    .gpio_out     (gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mem_b [NBYTES];
  logic [31:0] cnt_m;
  logic [31:0] gpio_m;

  int checks;
  int failures;
  logic [31:0] last_res;
  logic        last_mis;
  logic [31:0] last_gpio;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:4] == 28'hFFFFFFF;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] addr);
    logic [31:0] w;
    int sh;
    if (is_mmio(addr)) begin
      if (addr[3:2] == 2'd0) w = cnt_m;
      else if (addr[3:2] == 2'd1) w = gpio_m;
      else w = 32'd0;
      sh = 8 * int'(addr[1:0]);
      return 8'(w >> sh);
    end
    return mem_b[int'(addr % NBYTES)];
  endfunction

  function automatic logic ref_mis(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr);
    if (!(rd || wr)) return 1'b0;
    if (f3[1:0] == 2'd1 && addr[0]) return 1'b1;
    if (f3[1:0] == 2'd2 && addr[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic rd, input logic wr, input logic [2:0] f3,
                                           input logic [31:0] addr);
    logic [7:0] b0;
    logic [7:0] b1;
    logic [31:0] base;
    if (!rd || ref_mis(rd, wr, f3, addr)) return 32'd0;
    b0 = byte_at(addr);
    b1 = byte_at(addr + 32'd1);
    base = {addr[31:2], 2'b00};
    case (f3)
      3'd0: return 32'($signed(b0));
      3'd4: return {24'd0, b0};
      3'd1: return 32'($signed({b1, b0}));
      3'd5: return {16'd0, b1, b0};
      3'd2: return {byte_at(base + 32'd3), byte_at(base + 32'd2),
                    byte_at(base + 32'd1), byte_at(base)};
      default: return 32'd0;
    endcase
  endfunction

  // One pipeline cycle: drive, check combinational outputs, clock, update model.
  task automatic cyc(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    int nb;
    mem_readM = rd; mem_writeM = wr; funct3M = f3;
    alu_resultM = addr; write_dataM = wd;
    #2;
    last_res = dmem_resultM;
    last_mis = misalignM;
    last_gpio = gpio_out;
    chk("load_result", dmem_resultM, ref_load(rd, wr, f3, addr));
    chk("misalign", {31'd0, misalignM}, {31'd0, ref_mis(rd, wr, f3, addr)});
    chk("gpio", gpio_out, gpio_m);
    @(posedge clk);
    if (!rst_n) begin
      cnt_m = 32'd0;
      gpio_m = 32'd0;
    end else begin
      if (wr && !ref_mis(rd, wr, f3, addr) && f3 <= 3'd2) begin
        nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
          if (is_mmio(addr)) begin
            if (addr[3:2] == 2'd1) gpio_m[8*(int'(addr[1:0]) + k) +: 8] = wd[8*k +: 8];
          end else begin
            mem_b[int'((addr + 32'(k)) % NBYTES)] = wd[8*k +: 8];
          end
        end
      end
      cnt_m = cnt_m + 32'd1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v0;
    logic [31:0] a;
    checks = 0; failures = 0;
    cnt_m = 32'd0; gpio_m = 32'd0;
    rst_n = 1'b0; mem_readM = 1'b0; mem_writeM = 1'b0; funct3M = 3'd0;
    alu_resultM = 32'd0; write_dataM = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Counter reads 0 in first post-reset cycle; GPIO is reset.
    cyc(1'b1, 1'b0, 3'd2, 32'hFFFFFFF0, 32'd0);
    chk("cnt_after_reset", last_res, 32'd0);
    chk("gpio_reset", last_gpio, 32'd0);

    // Initialise the whole RAM to zero.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 3'd2, 32'(4 * i), 32'd0);

    // Word round-trip and alias.
    cyc(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    chk("lw_roundtrip", last_res, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 3'd2, 32'h10 + 32'(NBYTES), 32'd0);
    chk("lw_alias", last_res, 32'hDEADBEEF);

    // Sub-word store and load extension.
    cyc(1'b0, 1'b1, 3'd0, 32'h11, 32'h80);
    cyc(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    chk("lw_after_sb", last_res, 32'hDEAD80EF);
    cyc(1'b1, 1'b0, 3'd0, 32'h11, 32'd0);
    chk("lb", last_res, 32'hFFFFFF80);
    cyc(1'b1, 1'b0, 3'd4, 32'h11, 32'd0);
    chk("lbu", last_res, 32'h00000080);
    cyc(1'b1, 1'b0, 3'd1, 32'h12, 32'd0);
    chk("lh", last_res, 32'hFFFFDEAD);
    cyc(1'b1, 1'b0, 3'd5, 32'h12, 32'd0);
    chk("lhu", last_res, 32'h0000DEAD);

    // Misalignment.
    cyc(1'b0, 1'b1, 3'd2, 32'h20, 32'h0BADF00D);
    cyc(1'b0, 1'b1, 3'd1, 32'h21, 32'h1234);
    chk("sh_misalign_flag", {31'd0, last_mis}, 32'd1);
    cyc(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
    chk("sh_misalign_suppressed", last_res, 32'h0BADF00D);
    cyc(1'b1, 1'b0, 3'd2, 32'h22, 32'd0);
    chk("lw_misalign_flag", {31'd0, last_mis}, 32'd1);
    chk("lw_misalign_zero", last_res, 32'd0);
    cyc(1'b1, 1'b0, 3'd0, 32'h23, 32'd0);
    chk("lb_aligned_ok", {31'd0, last_mis}, 32'd0);

    // Read-before-write.
    cyc(1'b0, 1'b1, 3'd2, 32'h30, 32'h11111111);
    cyc(1'b1, 1'b1, 3'd2, 32'h30, 32'h22222222);
    chk("rbw_old", last_res, 32'h11111111);
    cyc(1'b1, 1'b0, 3'd2, 32'h30, 32'd0);
    chk("rbw_new", last_res, 32'h22222222);

    // MMIO GPIO and counter.
    cyc(1'b0, 1'b1, 3'd2, 32'hFFFFFFF4, 32'hA5A5A5A5);
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("gpio_sw", last_gpio, 32'hA5A5A5A5);
    cyc(1'b0, 1'b1, 3'd0, 32'hFFFFFFF5, 32'h00);
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("gpio_sb", last_gpio, 32'hA5A500A5);
    cyc(1'b1, 1'b0, 3'd2, 32'hFFFFFFF0, 32'd0);
    v0 = last_res;
    cyc(1'b0, 1'b1, 3'd2, 32'hFFFFFFF0, 32'h12345678);
    cyc(1'b1, 1'b0, 3'd2, 32'hFFFFFFF0, 32'd0);
    chk("cnt_write_ignored", last_res, v0 + 32'd2);
    v0 = last_res;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 3'd2, 32'hFFFFFFF0, 32'd0);
    chk("cnt_delta", last_res - v0, 32'd6);

    // Reset mid-operation.
    cyc(1'b0, 1'b1, 3'd2, 32'h40, 32'h1357);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 3'd2, 32'h40, 32'h5);
    cyc(1'b0, 1'b1, 3'd2, 32'hFFFFFFF4, 32'h7);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 3'd2, 32'hFFFFFFF0, 32'd0);
    chk("cnt_after_midreset", last_res, 32'd0);
    chk("gpio_after_midreset", last_gpio, 32'd0);
    cyc(1'b1, 1'b0, 3'd2, 32'h40, 32'd0);
    chk("ram_store_blocked", last_res, 32'h1357);

    // Randomized accesses against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        a = {28'hFFFFFFF, 4'($urandom_range(15))};
      end else begin
        a = $urandom;
        if (is_mmio(a)) a[31] = 1'b0;
      end
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
